// File: rtl/greater_than_serial.sv
// Serial magnitude comparator: scans operands MSB-first, B bits per cycle, stopping at the first differing digit.
// Define GREATER_THAN_SIGNED_EN to compare two's-complement operands instead of unsigned ones.
module greater_than_serial #(
    parameter int W = 8,
    parameter int B = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         done,
    output logic         gt,
    output logic         eq,
    output logic         lt
);

    localparam int N  = W / B;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((B < 1) || (B > W) || ((W % B) != 0)) begin : g_bad_params
            $error("greater_than_serial: B must divide W and satisfy 1 <= B <= W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [CW-1:0]  r_cnt;
    logic           r_gt;
    logic           r_eq;
    logic           r_lt;

    logic [W-1:0]   w_a_in;
    logic [W-1:0]   w_b_in;
    logic [B-1:0]   w_dig_a;
    logic [B-1:0]   w_dig_b;
    logic           w_last;
    logic           w_differ;

`ifdef GREATER_THAN_SIGNED_EN
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [W-1:0] SIGN_MASK = W'(1) << (W - 1);
    assign w_a_in = a ^ SIGN_MASK;
    assign w_b_in = b ^ SIGN_MASK;
`else
    assign w_a_in = a;
    assign w_b_in = b;
`endif

    assign w_dig_a  = r_a[W-1 -: B];
    assign w_dig_b  = r_b[W-1 -: B];
    assign w_differ = (w_dig_a != w_dig_b);
    assign w_last   = (r_cnt == CW'(N - 1));

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: default assigned first so no path leaves w_state_next unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_next = S_CMP;
            S_CMP:   if (w_differ || w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_gt  <= 1'b0;
            r_eq  <= 1'b1;
            r_lt  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= w_a_in;
                        r_b   <= w_b_in;
                        r_cnt <= '0;
                    end
                end
                S_CMP: begin
                    // Flags only move on completion, so they hold the previous result while scanning.
                    if (w_dig_a > w_dig_b) begin
                        r_gt <= 1'b1;
                        r_eq <= 1'b0;
                        r_lt <= 1'b0;
                    end else if (w_dig_a < w_dig_b) begin
                        r_gt <= 1'b0;
                        r_eq <= 1'b0;
                        r_lt <= 1'b1;
                    end else if (w_last) begin
                        r_gt <= 1'b0;
                        r_eq <= 1'b1;
                        r_lt <= 1'b0;
                    end else begin
                        r_a   <= r_a << B;
                        r_b   <= r_b << B;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready = (r_state == S_IDLE);
    assign done  = (r_state == S_DONE);
    assign gt    = r_gt;
    assign eq    = r_eq;
    assign lt    = r_lt;

endmodule

// File: tb/tb_greater_than_serial.sv
// Scoreboard bench for greater_than_serial: an 8-bit/B=2 instance plus 4-bit B=1 and B=4 instances for exhaustive sweeps.
// Expected flags and done timing come from plain integer comparison of the operands.
module tb_greater_than_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       s_start;
    logic [3:0] s_a;
    logic [3:0] s_b;

    logic ready8, done8, gt8, eq8, lt8;
    logic ready41, done41, gt41, eq41, lt41;
    logic ready44, done44, gt44, eq44, lt44;

    greater_than_serial #(.W(8), .B(2)) u_dut8 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .ready(ready8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8)
    );

    greater_than_serial #(.W(4), .B(1)) u_dut41 (
        .clk(clk), .reset(reset), .start(s_start), .a(s_a), .b(s_b),
        .ready(ready41), .done(done41), .gt(gt41), .eq(eq41), .lt(lt41)
    );

    greater_than_serial #(.W(4), .B(4)) u_dut44 (
        .clk(clk), .reset(reset), .start(s_start), .a(s_a), .b(s_b),
        .ready(ready44), .done(done44), .gt(gt44), .eq(eq44), .lt(lt44)
    );

    // Number of rising edges seen so far; the accepting edge of a start is cyc+1 when driven.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic gt;
        logic eq;
        logic lt;
        int   cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q41[$];
    exp_t q44[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected result of one comparison accepted at edge acc: ordering of the operand values,
    // and done visible after edge acc+k, k being the MSB-first index of the first differing digit.
    function automatic exp_t model(input int w, input int bw, input int av, input int bv, input int acc);
        exp_t r;
        int   sa;
        int   sb;
        int   x;
        int   msb;
        int   k;
        sa = av;
        sb = bv;
`ifdef GREATER_THAN_SIGNED_EN
        if (av >= (1 << (w - 1))) sa = av - (1 << w);
        if (bv >= (1 << (w - 1))) sb = bv - (1 << w);
`endif
        r.gt = (sa > sb);
        r.eq = (sa == sb);
        r.lt = (sa < sb);
        x = av ^ bv;
        if (x == 0) begin
            k = w / bw;
        end else begin
            msb = 0;
            for (int i = 0; i < w; i++) if (x[i]) msb = i;
            k = (w - 1 - msb) / bw + 1;
        end
        r.cyc = acc + k;
        return r;
    endfunction

    // Monitor: samples on the falling edge, pops an expectation whenever a DUT pulses done.
    logic [2:0] prev8 = 3'b010;
    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            if (q8.size() == 0) check("dut8 unexpected done", 1, 0);
            else begin
                e = q8.pop_front();
                check("dut8 flags gt/eq/lt", {gt8, eq8, lt8}, {e.gt, e.eq, e.lt});
                check("dut8 done cycle", cyc, e.cyc);
            end
        end
        if (done41) begin
            if (q41.size() == 0) check("dut41 unexpected done", 1, 0);
            else begin
                e = q41.pop_front();
                check("dut41 flags gt/eq/lt", {gt41, eq41, lt41}, {e.gt, e.eq, e.lt});
                check("dut41 done cycle", cyc, e.cyc);
            end
        end
        if (done44) begin
            if (q44.size() == 0) check("dut44 unexpected done", 1, 0);
            else begin
                e = q44.pop_front();
                check("dut44 flags gt/eq/lt", {gt44, eq44, lt44}, {e.gt, e.eq, e.lt});
                check("dut44 done cycle", cyc, e.cyc);
            end
        end
        // Flags may only change when a result is presented or under reset.
        if ({gt8, eq8, lt8} != prev8) check("dut8 flags change only at done/reset", done8 | reset, 1);
        prev8 = {gt8, eq8, lt8};
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready8();
        int t = 0;
        while (!ready8 && t < 100) begin
            tick();
            t++;
        end
        if (!ready8) check("dut8 ready timeout", 0, 1);
    endtask

    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, output int k);
        exp_t e;
        int   acc;
        wait_ready8();
        start = 1'b1;
        a     = av;
        b     = bv;
        acc   = cyc + 1;
        e     = model(8, 2, int'(av), int'(bv), acc);
        k     = e.cyc - acc;
        q8.push_back(e);
        tick();
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        check("dut8 ready low after accept", ready8, 0);
    endtask

    initial begin
        int         k;
        int         t;
        logic [7:0] av;
        logic [7:0] bv;
        reset   = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        s_start = 1'b0;
        s_a     = '0;
        s_b     = '0;
        repeat (3) tick();
        check("reset ready", ready8, 1);
        check("reset done", done8, 0);
        check("reset gt/eq/lt", {gt8, eq8, lt8}, 3'b010);
        check("reset dut41 ready/flags", {ready41, gt41, eq41, lt41}, 4'b1010);
        check("reset dut44 ready/flags", {ready44, gt44, eq44, lt44}, 4'b1010);

        // Reset wins over a simultaneous start.
        start = 1'b1;
        a     = 8'hC0;
        b     = 8'h40;
        tick();
        check("reset priority over start", ready8, 1);
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("still idle after reset+start", ready8, 1);

        issue8(8'hC0, 8'h40, k);
        issue8(8'h5A, 8'h5A, k);
        issue8(8'h01, 8'h02, k);
        issue8(8'h80, 8'h01, k);

        // Start hammered with fresh operands through CMP and DONE must be ignored.
        issue8(8'h5A, 8'h5B, k);
        for (int i = 0; i <= k; i++) begin
            check("ready low while busy", ready8, 0);
            start = 1'b1;
            a     = 8'($urandom);
            b     = 8'($urandom);
            tick();
        end
        start = 1'b0;
        tick();

        // Reset in the second CMP cycle aborts without a done pulse.
        issue8(8'hFF, 8'hFF, k);
        tick();
        reset = 1'b1;
        q8.delete();
        tick();
        check("abort ready", ready8, 1);
        check("abort done", done8, 0);
        check("abort gt/eq/lt", {gt8, eq8, lt8}, 3'b010);
        reset = 1'b0;
        issue8(8'h10, 8'h20, k);

        for (int i = 0; i < 40; i++) begin
            av = 8'($urandom);
            if (i % 5 == 0) bv = av;
            else if (i % 2 == 0) bv = av ^ (8'(1) << $urandom_range(7, 0));
            else bv = 8'($urandom);
            issue8(av, bv, k);
        end

        // Exhaustive 4-bit sweeps, both instances driven together.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                t = 0;
                while (!(ready41 && ready44) && t < 100) begin
                    tick();
                    t++;
                end
                if (!(ready41 && ready44)) check("sweep ready timeout", 0, 1);
                s_start = 1'b1;
                s_a     = 4'(ai);
                s_b     = 4'(bi);
                q41.push_back(model(4, 1, ai, bi, cyc + 1));
                q44.push_back(model(4, 4, ai, bi, cyc + 1));
                tick();
                s_start = 1'b0;
                s_a     = 4'($urandom);
                s_b     = 4'($urandom);
            end
        end

        t = 0;
        while ((q8.size() + q41.size() + q44.size()) != 0 && t < 200) begin
            tick();
            t++;
        end
        check("dut8 results outstanding", q8.size(), 0);
        check("dut41 results outstanding", q41.size(), 0);
        check("dut44 results outstanding", q44.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/greater_than_serial.md
GREATER_THAN_SERIAL -- requirements
Module: greater_than_serial

Interface
REQ-001 SHALL have parameter W, default 8: operand width in bits.
REQ-002 SHALL have parameter B, default 2: digit width compared per cycle; W mod B = 0 and 1 <= B <= W are required, with legality checked at elaboration.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: request a comparison; sampled only when ready=1.
REQ-006 SHALL have port a, input, W: first operand, sampled on the accepted start edge.
REQ-007 SHALL have port b, input, W: second operand, sampled on the accepted start edge.
REQ-008 SHALL have port ready, output, 1: high in IDLE only.
REQ-009 SHALL have port done, output, 1: one-cycle pulse; result valid.
REQ-010 SHALL have ports gt, eq and lt, each output, 1: result flags; exactly one is high after the first completed compare.

Function
REQ-011 SHALL implement FSM states IDLE, CMP and DONE.
REQ-012 SHALL, in IDLE, accept start=1 at a clock edge by latching a and b into shift registers, clearing the digit counter and moving to CMP. In IDLE with start=0 it stays in IDLE.
REQ-013 SHALL, in CMP, at each edge compare the top B-bit digits of the latched operands, most significant digit first.
REQ-014 SHALL, when those digits differ, register gt or lt from that digit comparison and go to DONE (early termination).
REQ-015 SHALL, when those digits are equal and are not the last digit, shift both registers left by B and increment the counter.
REQ-016 SHALL, when those digits are equal and are the last digit (counter = W/B-1), register eq=1 and go to DONE.
REQ-017 SHALL define latency as follows: done is high in the cycle after the k-th CMP edge, where k is the 1-based index (from the MSB) of the first differing digit, or k = W/B if the operands are equal. The range is 1..W/B.
REQ-018 SHALL hold done=1 for exactly one cycle in DONE, then go to IDLE unconditionally.
REQ-019 SHALL hold gt, eq and lt stable from DONE until the next result is registered; they do not change while CMP is in progress.
REQ-020 SHALL ignore start while in CMP or DONE; operands are not re-sampled and there is no queuing.
REQ-021 SHALL give back-to-back throughput of one comparison per k+2 cycles: the accept edge plus k CMP edges plus the DONE cycle.
REQ-022 SHALL accept operand changes on a and b after the accept edge with no effect on the result in progress.
REQ-023 SHALL, with B = W, degenerate to a fixed 1-cycle compare with identical handshake timing (k=1).

Reset
REQ-024 SHALL, while reset=1 at a rising edge, force state=IDLE, ready=1 (combinational from state), done=0, gt=0, lt=0, eq=1, and clear the counter and shift registers.
REQ-025 SHALL, on reset during CMP or DONE, abort the comparison with no done pulse; the next start after reset is accepted normally.
REQ-026 SHALL give reset priority over start in the same cycle.

Configuration
REQ-027 SHALL, when macro GREATER_THAN_SIGNED_EN is defined, treat operands as two's complement by inverting bit W-1 of both a and b at latch time; ordering is then signed.
REQ-028 SHALL, when GREATER_THAN_SIGNED_EN is undefined, compare operands as unsigned; the latch path has no inversion logic.

Verification (W=8, B=2 unless noted)
REQ-029 SHALL cover: start with a=8'hC0, b=8'h40 -> done one cycle after the accept edge (k=1), gt=1, eq=0, lt=0.
REQ-030 SHALL cover: start with a=b=8'h5A -> done after k=4, eq=1; then start with a=8'h01, b=8'h02 -> done after k=4, lt=1.
REQ-031 SHALL cover: a=8'h80, b=8'h01 -> gt=1 without GREATER_THAN_SIGNED_EN; lt=1 with it defined (-128 < 1).
REQ-032 SHALL cover: start re-asserted with new operands every cycle during CMP -> ignored; first result unchanged, ready=0 until IDLE.
REQ-033 SHALL cover: reset asserted at the 2nd CMP cycle of a=b=8'hFF -> no done pulse, eq=1, ready=1 next cycle; a following start with a=8'h10, b=8'h20 -> lt=1 after k=2.
REQ-034 SHALL cover: exhaustive sweep with W=4, B=1 and with W=4, B=4 -> flags match a reference compare, and latency equals first-differing-digit index for all 256 pairs.
